// File: rtl/input_sample_buffer.sv
// Per-channel circular sample history for the filter datapath, with delayed
// reads x[n-k] (zero outside recorded history) and per-channel zero-run sleep flags.

module isb_zero_det #(
    parameter int WIDTH      = 16,
    parameter int ZERO_LIMIT = 800
) (
    input  logic             SCLK,
    input  logic             clear,
    input  logic             acc_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             sleep_o
);
    localparam int ZW = $clog2(ZERO_LIMIT + 1);
    localparam logic [ZW-1:0] ZLIM = ZW'(ZERO_LIMIT);

    logic [ZW-1:0] zc_q, zc_d;
    logic          sleep_q;

    // Counter saturates at the limit so a long silence keeps sleep asserted.
    always_comb begin
        zc_d = zc_q;
        if (acc_i) begin
            if (din_i == '0) begin
                if (zc_q != ZLIM) zc_d = zc_q + 1'b1;
            end else begin
                zc_d = '0;
            end
        end
    end

    always_ff @(posedge SCLK) begin
        if (!clear) begin
            zc_q    <= '0;
            sleep_q <= 1'b0;
        end else begin
            zc_q    <= zc_d;
            sleep_q <= (zc_d == ZLIM);
        end
    end

    assign sleep_o = sleep_q;
endmodule

module input_sample_buffer #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 256,
    parameter int ZERO_LIMIT = 800
) (
    input  logic                     SCLK,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_l,
    input  logic [WIDTH-1:0]         in_r,
    input  logic                     run_en,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_k,
    output logic [WIDTH-1:0]         rd_l,
    output logic [WIDTH-1:0]         rd_r,
    output logic                     rd_valid,
    output logic                     new_sample,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     sleep_l,
    output logic                     sleep_r
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_l [DEPTH];
    logic [WIDTH-1:0] mem_r [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic [WIDTH-1:0] rd_l_q, rd_l_d, rd_r_q, rd_r_d;
    logic             rd_valid_q, new_sample_q;
    logic             acc;
    logic [AW-1:0]    rd_addr;
    logic             in_hist;

    assign acc     = in_valid & run_en;
    // Wrap arithmetic in AW bits; reads always see the pre-write pointer and fill.
    assign rd_addr = wr_ptr_q - 1'b1 - rd_k;
    assign in_hist = ({1'b0, rd_k} < fill_q);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        rd_l_d   = rd_l_q;
        rd_r_d   = rd_r_q;
        if (acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != FULL) fill_d = fill_q + 1'b1;
        end
        if (rd_en) begin
            rd_l_d = in_hist ? mem_l[rd_addr] : '0;
            rd_r_d = in_hist ? mem_r[rd_addr] : '0;
        end
    end

    always_ff @(posedge SCLK) begin
        if (!clear) begin
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            rd_l_q       <= '0;
            rd_r_q       <= '0;
            rd_valid_q   <= 1'b0;
            new_sample_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            rd_l_q       <= rd_l_d;
            rd_r_q       <= rd_r_d;
            rd_valid_q   <= rd_en;
            new_sample_q <= acc;
        end
    end

    // Sample storage is intentionally not reset; fill masks stale contents.
    always_ff @(posedge SCLK) begin
        if (clear && acc) begin
            mem_l[wr_ptr_q] <= in_l;
            mem_r[wr_ptr_q] <= in_r;
        end
    end

    isb_zero_det #(.WIDTH(WIDTH), .ZERO_LIMIT(ZERO_LIMIT)) u_zd_l (
        .SCLK(SCLK), .clear(clear), .acc_i(acc), .din_i(in_l), .sleep_o(sleep_l)
    );
    isb_zero_det #(.WIDTH(WIDTH), .ZERO_LIMIT(ZERO_LIMIT)) u_zd_r (
        .SCLK(SCLK), .clear(clear), .acc_i(acc), .din_i(in_r), .sleep_o(sleep_r)
    );

    assign rd_l       = rd_l_q;
    assign rd_r       = rd_r_q;
    assign rd_valid   = rd_valid_q;
    assign new_sample = new_sample_q;
    assign fill       = fill_q;
endmodule

// File: tb/tb_input_sample_buffer.sv
// Directed bench for input_sample_buffer: read data checked through a scoreboard
// queue drained by a monitor; fill and flag outputs checked inline.

module tb_input_sample_buffer;
    logic        SCLK = 1'b0;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_l, in_r;
    logic        run_en;
    logic        rd_en;
    logic [7:0]  rd_k;
    logic [15:0] rd_l, rd_r;
    logic        rd_valid, new_sample;
    logic [8:0]  fill;
    logic        sleep_l, sleep_r;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    input_sample_buffer #(.WIDTH(16), .DEPTH(256), .ZERO_LIMIT(800)) dut (
        .SCLK(SCLK), .clear(clear), .in_valid(in_valid), .in_l(in_l), .in_r(in_r),
        .run_en(run_en), .rd_en(rd_en), .rd_k(rd_k), .rd_l(rd_l), .rd_r(rd_r),
        .rd_valid(rd_valid), .new_sample(new_sample), .fill(fill),
        .sleep_l(sleep_l), .sleep_r(sleep_r)
    );

    always #5 SCLK = ~SCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid cycle must match the oldest outstanding expectation.
    always @(negedge SCLK) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read", {rd_l, rd_r});
            end else begin
                chk("rd_data", {rd_l, rd_r}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic accept(input logic [15:0] l, input logic [15:0] r);
        in_valid = 1'b1; in_l = l; in_r = r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] k, input logic [15:0] el, input logic [15:0] er);
        rd_en = 1'b1; rd_k = k;
        exp_q.push_back({el, er});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        tick(); tick();
        clear = 1'b1;
    endtask

    initial begin
        clear = 1'b0; in_valid = 1'b0; in_l = '0; in_r = '0;
        run_en = 1'b1; rd_en = 1'b0; rd_k = '0;

        // Reset state and reads of empty history
        do_reset();
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_flags", {new_sample, sleep_l, sleep_r, rd_valid}, 32'h0);
        chk("rst_rd", {rd_l, rd_r}, 32'h0);
        for (int k = 0; k < 4; k++) rd(8'(k), 16'h0, 16'h0);

        // Ordered history, back-to-back accepts
        for (int i = 1; i <= 5; i++) accept(16'(i), 16'h8000 + 16'(i));
        chk("ns_after_acc", 32'(new_sample), 32'd1);
        chk("fill5", 32'(fill), 32'd5);
        rd(8'd0, 16'h0005, 16'h8005);
        rd(8'd2, 16'h0003, 16'h8003);
        rd(8'd4, 16'h0001, 16'h8001);
        rd(8'd5, 16'h0000, 16'h0000);
        tick();
        chk("ns_idle", 32'(new_sample), 32'd0);

        // Run gating: pulse dropped
        run_en = 1'b0;
        accept(16'h1234, 16'h5678);
        chk("gate_ns", 32'(new_sample), 32'd0);
        chk("gate_fill", 32'(fill), 32'd5);
        run_en = 1'b1;
        rd(8'd0, 16'h0005, 16'h8005);

        // Accept and read k=0 in the same cycle
        in_valid = 1'b1; in_l = 16'h0006; in_r = 16'h8006;
        rd(8'd0, 16'h0005, 16'h8005);
        in_valid = 1'b0;
        chk("coll_ns", 32'(new_sample), 32'd1);
        chk("coll_fill", 32'(fill), 32'd6);
        rd(8'd0, 16'h0006, 16'h8006);

        // Mid-stream reset colliding with an accept (10 accepts so far)
        for (int i = 7; i <= 10; i++) accept(16'(i), 16'h8000 + 16'(i));
        chk("fill10", 32'(fill), 32'd10);
        clear = 1'b0; in_valid = 1'b1; in_l = 16'h0077; in_r = 16'h0077;
        tick();
        clear = 1'b1; in_valid = 1'b0;
        chk("mrst_fill", 32'(fill), 32'd0);
        chk("mrst_ns", 32'(new_sample), 32'd0);
        rd(8'd0, 16'h0, 16'h0);
        rd(8'd1, 16'h0, 16'h0);
        rd(8'd9, 16'h0, 16'h0);

        // Wrap-around: 300 samples, L=index, R=index+0x1000
        for (int i = 0; i < 300; i++) accept(16'(i), 16'h1000 + 16'(i));
        chk("wrap_fill", 32'(fill), 32'd256);
        rd(8'd0,   16'd299, 16'h112B);
        rd(8'd255, 16'd44,  16'h102C);
        rd(8'd1,   16'd298, 16'h112A);

        // Sleep: L goes silent, R stays active until the last sample
        do_reset();
        for (int i = 0; i < 799; i++) accept(16'h0, 16'h0001);
        chk("sleep_799", {sleep_l, sleep_r}, 32'h0);
        accept(16'h0, 16'h0);
        chk("sleep_800", {sleep_l, sleep_r}, 32'h2);
        tick();
        chk("sleep_hold", {sleep_l, sleep_r}, 32'h2);
        accept(16'h0010, 16'h0);
        chk("wake", {sleep_l, sleep_r}, 32'h0);
        rd(8'd0, 16'h0010, 16'h0000);
        rd(8'd1, 16'h0000, 16'h0000);

        // Drain outstanding reads within a bounded window
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/input_sample_buffer.md
# input_sample_buffer

Circular sample store sitting directly downstream of the serial-to-parallel converter in the SCLK domain. Accepts each 16-bit left/right word pair on the converter's one-cycle `ready` pulse and writes it into per-channel circular buffers. Serves the filter datapath with delayed samples x[n-k], with out-of-history samples reading as zero. Tracks consecutive all-zero input per channel to flag MSDAP sleep.

## Interface
Parameters:
- `WIDTH`, 16, sample width in bits
- `DEPTH`, 256, samples kept per channel; must be a power of 2
- `ZERO_LIMIT`, 800, consecutive zero samples before a channel's sleep flag asserts

Ports:
- `SCLK`  in  1  system clock, all logic on rising edge; the only clock
- `clear`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  one-cycle pulse: new sample pair present (driven by converter `ready`)
- `in_l`, `in_r`  in  WIDTH  left/right sample, sampled when `in_valid`=1
- `run_en`  in  1  1 = accept samples; 0 = drop `in_valid` pulses (coefficient-load phase)
- `rd_en`  in  1  read request
- `rd_k`  in  $clog2(DEPTH)  delay index k; 0 = newest sample
- `rd_l`, `rd_r`  out  WIDTH  registered read data x[n-k]
- `rd_valid`  out  1  high the cycle `rd_l`/`rd_r` are updated
- `new_sample`  out  1  one-cycle pulse after each accepted write
- `fill`  out  $clog2(DEPTH)+1  samples held, saturates at DEPTH
- `sleep_l`, `sleep_r`  out  1  channel has seen ≥ ZERO_LIMIT consecutive zeros

## Operation
- Accept = `in_valid` & `run_en`. On accept, `mem_l[wr_ptr]` ← `in_l` and `mem_r[wr_ptr]` ← `in_r`. `wr_ptr` ← `wr_ptr`+1 mod DEPTH, wrapping 255→0 with no flag. `fill` ← min(`fill`+1, DEPTH).
- `in_valid` with `run_en`=0 is ignored: no change to pointer, fill, zero counters or `new_sample`.
- Read address = (`wr_ptr` − 1 − `rd_k`) mod DEPTH, computed in $clog2(DEPTH)-bit unsigned wrap arithmetic.
- Read data when `rd_k` ≥ `fill`: both channels return 0. This implements x[n-k]=0 for k>n. Memory is not cleared at reset.
- Read and accept in the same cycle: the read uses the pre-write `wr_ptr` and `fill`, so k=0 returns the previous newest sample.
- Zero detect, per channel and independent:
  - Counter `zc` counts only on accept. A sample equal to 0 gives `zc` ← min(`zc`+1, ZERO_LIMIT); a nonzero sample gives `zc` ← 0.
  - `sleep_x` = (`zc` == ZERO_LIMIT), registered.
  - A nonzero sample is still written normally and clears sleep.
- Reset (`clear`=0 at a rising edge) overrides any accept or read in that cycle. Result: `wr_ptr`=0, `fill`=0, both `zc`=0, `rd_l`=`rd_r`=0, `rd_valid`=0, `new_sample`=0, `sleep_l`=`sleep_r`=0. Reset mid-stream discards all history: every subsequent read returns 0 until new writes arrive.

## Timing
- Accept at edge t: `new_sample`=1 in cycle t+1 only; `fill` and `wr_ptr` are updated in t+1.
- Read latency is 1: `rd_en` sampled at edge t gives `rd_l`/`rd_r`/`rd_valid` valid in cycle t+1. `rd_l`/`rd_r` hold their value when `rd_en`=0, and `rd_valid`=0.
- Back-to-back reads, one per cycle, are supported with no bubbles.
- `in_valid` pulses are expected at ≥ 2 cycles apart (converter ready rate ≈ 1 per 560 SCLK). Consecutive-cycle pulses are still each accepted correctly.
- Sleep asserts in the cycle after the ZERO_LIMIT-th consecutive zero is accepted. It deasserts in the cycle after the first nonzero is accepted.

## Test plan
- Reset then reads: `clear`=0 for 2 cycles, release, then `rd_en` with k=0..3 → `rd_l`=`rd_r`=0, `fill`=0, all flags 0.
- Ordered history: accept L=0x0001..0x0005 and R=0x8001..0x8005, then read k=0,2,4 → L 0x0005/0x0003/0x0001, R 0x8005/0x8003/0x8001. Read k=5 → 0.
- Wrap-around: accept 300 samples with L=index, then read k=0 → 299 and k=255 → 44. `fill`=256.
- Run gating and collision:
  - Pulse `in_valid` with `run_en`=0 → no `new_sample`, `fill` unchanged.
  - Accept plus read k=0 in the same cycle → returns the prior sample; the next k=0 read returns the new one.
- Sleep: accept 799 zeros on L → `sleep_l`=0. The 800th zero → `sleep_l`=1 next cycle, and `sleep_r` follows its own data. Then L=0x0010 → `sleep_l`=0 next cycle and k=0 reads 0x0010.
- Mid-stream reset: after 10 accepts, pulse `clear`=0 in the same cycle as an accept → write is dropped, `fill`=0, all reads return 0.
